// File: rtl/seq_div_pkg.sv
// Shared types and defaults for the sequential restoring divider.
// FSM state encoding lives here so every file agrees on it.
package seq_div_pkg;

    localparam int DVD_W_DEF = 8;
    localparam int DVS_W_DEF = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_e;

endpackage

// File: rtl/seq_div_if.sv
// Operand/result handshake bundle for seq_div.
// The master drives the operands and consumes the results; the divider is the slave.
interface seq_div_if
    import seq_div_pkg::*;
#(
    parameter int DVD_W = DVD_W_DEF,
    parameter int DVS_W = DVS_W_DEF
);

    logic             in_valid;
    logic             in_ready;
    logic [DVD_W-1:0] dividend;
    logic [DVS_W-1:0] divisor;
    logic             out_valid;
    logic             out_ready;
    logic [DVD_W-1:0] quotient;
    logic [DVS_W-1:0] remainder;
    logic             dz;
    logic             ovf;

    modport master (
        output in_valid, dividend, divisor, out_ready,
        input  in_ready, out_valid, quotient, remainder, dz, ovf
    );

    modport slave (
        input  in_valid, dividend, divisor, out_ready,
        output in_ready, out_valid, quotient, remainder, dz, ovf
    );

endinterface

// File: rtl/seq_div_step.sv
// One radix-2 restoring division step: shift in a dividend bit, subtract the
// divisor if it fits, and report the resulting quotient bit.
module seq_div_step #(
    parameter int DVS_W = 4
) (
    input  logic [DVS_W:0]   pr,
    input  logic             dvd_bit,
    input  logic [DVS_W-1:0] divisor,
    output logic [DVS_W:0]   pr_next,
    output logic             q_bit
);

    logic [DVS_W+1:0] shifted;

    // The partial remainder stays below the divisor, so the shifted value
    // always fits back into DVS_W+1 bits after the conditional subtract.
    assign shifted = {pr, dvd_bit};
    assign q_bit   = shifted >= {2'b00, divisor};
    assign pr_next = q_bit ? (shifted[DVS_W:0] - {1'b0, divisor}) : shifted[DVS_W:0];

endmodule

// File: rtl/seq_div.sv
// Sequential restoring divider with valid/ready handshakes on both sides.
// Optional feature macro: SEQ_DIV_SIGNED_EN (two's-complement operands, ovf flag).
module seq_div
    import seq_div_pkg::*;
#(
    parameter int DVD_W = DVD_W_DEF,
    parameter int DVS_W = DVS_W_DEF
) (
    input  logic     clk,
    input  logic     rst,
    seq_div_if.slave bus
);

    localparam int CNT_W = $clog2(DVD_W);

    state_e           state, state_next;
    logic [DVD_W-1:0] dvd_sh;
    logic [DVS_W-1:0] dvs_q;
    logic [DVS_W:0]   pr_q, pr_next;
    logic [CNT_W-1:0] cnt;
    logic             dz_pend;
    logic             q_bit;
    logic             accept, last, finish, stepping;
    logic [DVD_W-1:0] q_mag, res_q, quo_q;
    logic [DVS_W-1:0] r_mag, res_r, rem_q;
    logic             dz_q;

    assign accept   = bus.in_valid && (state == IDLE);
    assign last     = cnt == CNT_W'(DVD_W - 1);
    assign stepping = (state == CALC) && !dz_pend;
    assign finish   = (state == CALC) && (dz_pend || last);

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples pre-edge values regardless of block ordering.
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_comb begin
        // NOTE: default first, so no path through the case leaves state_next
        // unassigned and infers a latch.
        state_next = state;
        case (state)
            IDLE:    if (bus.in_valid) state_next = CALC;
            CALC:    if (dz_pend || last) state_next = DONE;
            DONE:    if (bus.out_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    seq_div_step #(.DVS_W(DVS_W)) u_step (
        .pr      (pr_q),
        .dvd_bit (dvd_sh[DVD_W-1]),
        .divisor (dvs_q),
        .pr_next (pr_next),
        .q_bit   (q_bit)
    );

    // Dividend bits leave at the top while quotient bits enter at the bottom,
    // so after the last step this register plus the final bit is the quotient.
    assign q_mag = {dvd_sh[DVD_W-2:0], q_bit};
    assign r_mag = pr_next[DVS_W-1:0];

`ifdef SEQ_DIV_SIGNED_EN
    localparam logic [DVD_W-1:0] Q_MIN_MAG = {1'b1, {(DVD_W-1){1'b0}}};

    logic dvd_neg, dvs_neg, q_neg, res_ovf, ovf_q;

    always_comb begin
        q_neg   = dvd_neg ^ dvs_neg;
        res_q   = q_neg ? -q_mag : q_mag;
        res_r   = dvd_neg ? -r_mag : r_mag;
        res_ovf = q_neg ? (q_mag > Q_MIN_MAG) : q_mag[DVD_W-1];
        if (dz_pend) begin
            res_q   = '1;
            res_r   = dvd_sh[DVS_W-1:0];
            res_ovf = 1'b0;
        end
    end
`else
    always_comb begin
        res_q = dz_pend ? '1 : q_mag;
        res_r = dz_pend ? dvd_sh[DVS_W-1:0] : r_mag;
    end
`endif

    // NOTE: operand/shift registers carry no reset; they are always loaded
    // on accept before anything reads them, so a reset would only cost routing.
    always_ff @(posedge clk) begin
        if (accept) begin
            dz_pend <= bus.divisor == '0;
`ifdef SEQ_DIV_SIGNED_EN
            dvd_neg <= bus.dividend[DVD_W-1];
            dvs_neg <= bus.divisor[DVS_W-1];
            // A zero divisor keeps the raw dividend for the remainder output.
            dvd_sh  <= (bus.divisor == '0 || !bus.dividend[DVD_W-1]) ? bus.dividend : -bus.dividend;
            dvs_q   <= bus.divisor[DVS_W-1] ? -bus.divisor : bus.divisor;
`else
            dvd_sh  <= bus.dividend;
            dvs_q   <= bus.divisor;
`endif
        end else if (stepping) begin
            dvd_sh <= q_mag;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pr_q  <= '0;
            cnt   <= '0;
            quo_q <= '0;
            rem_q <= '0;
            dz_q  <= 1'b0;
`ifdef SEQ_DIV_SIGNED_EN
            ovf_q <= 1'b0;
`endif
        end else begin
            if (accept) begin
                pr_q <= '0;
                cnt  <= '0;
            end else if (stepping) begin
                pr_q <= pr_next;
                cnt  <= cnt + CNT_W'(1);
            end
            if (finish) begin
                quo_q <= res_q;
                rem_q <= res_r;
                dz_q  <= dz_pend;
`ifdef SEQ_DIV_SIGNED_EN
                ovf_q <= res_ovf;
`endif
            end
        end
    end

    assign bus.in_ready  = state == IDLE;
    assign bus.out_valid = state == DONE;
    assign bus.quotient  = quo_q;
    assign bus.remainder = rem_q;
    assign bus.dz        = dz_q;
`ifdef SEQ_DIV_SIGNED_EN
    assign bus.ovf       = ovf_q;
`else
    assign bus.ovf       = 1'b0;
`endif

endmodule
